// File: rtl/sram_arb_pkg.sv
// Shared types and sizes for the two-port SRAM arbiter.
//   arb_state_t : arbiter FSM states
//   mem_req_t   : one latched SRAM request (wren, addr, wdata, bmask)
//   make_req()  : packs the request fields of one port into a mem_req_t
package sram_arb_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 32;
  localparam int SRAM_BW = SRAM_DW / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_A = 2'd1,
    BUSY_B = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic               wren;
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] wdata;
    logic [SRAM_BW-1:0] bmask;
  } mem_req_t;

  function automatic mem_req_t make_req(
    input logic               wren,
    input logic [SRAM_AW-1:0] addr,
    input logic [SRAM_DW-1:0] wdata,
    input logic [SRAM_BW-1:0] bmask
  );
    mem_req_t r;
    r.wren  = wren;
    r.addr  = addr;
    r.wdata = wdata;
    r.bmask = bmask;
    return r;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin pick.
//   req[1:0]   : request vector, bit 0 = port A, bit 1 = port B
//   last_grant : port granted most recently (0 = A, 1 = B)
//   grant[1:0] : one-hot winner, all zero when nobody requests
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // On a tie the port that did not win last time goes first.
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates an LSU port (A) and an instruction-fetch port (B) onto a single
// 32-bit SRAM controller, one transaction outstanding at a time.
//   i_clk, i_rst_n           : clock, asynchronous active-low reset
//   i_x_req/wren/addr/wdata/bmask : per-port request (x = a, b)
//   o_x_rdata, o_x_ack       : per-port registered read data, completion pulse
//   o_mem_*                  : request to the SRAM controller (all registered)
//   i_mem_rdata, i_mem_ack   : response from the SRAM controller
//   o_timeout_err            : sticky, set when a transaction is aborted
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_a_req,
  input  logic               i_a_wren,
  input  logic [SRAM_AW-1:0] i_a_addr,
  input  logic [SRAM_DW-1:0] i_a_wdata,
  input  logic [SRAM_BW-1:0] i_a_bmask,
  input  logic               i_b_req,
  input  logic               i_b_wren,
  input  logic [SRAM_AW-1:0] i_b_addr,
  input  logic [SRAM_DW-1:0] i_b_wdata,
  input  logic [SRAM_BW-1:0] i_b_bmask,
  output logic [SRAM_DW-1:0] o_a_rdata,
  output logic               o_a_ack,
  output logic [SRAM_DW-1:0] o_b_rdata,
  output logic               o_b_ack,
  output logic [SRAM_AW-1:0] o_mem_addr,
  output logic [SRAM_DW-1:0] o_mem_wdata,
  output logic [SRAM_BW-1:0] o_mem_bmask,
  output logic               o_mem_wren,
  output logic               o_mem_rden,
  input  logic [SRAM_DW-1:0] i_mem_rdata,
  input  logic               i_mem_ack,
  output logic               o_timeout_err
);

  // Counter value in the last BUSY cycle before an abort.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  arb_state_t         state_reg, state_next;
  mem_req_t           lat_reg, lat_next;
  logic [7:0]         cnt_reg, cnt_next;
  logic               rden_reg, rden_next;
  logic               wren_reg, wren_next;
  logic               a_ack_reg, a_ack_next;
  logic               b_ack_reg, b_ack_next;
  logic [SRAM_DW-1:0] a_rdata_reg, a_rdata_next;
  logic [SRAM_DW-1:0] b_rdata_reg, b_rdata_next;
  logic               terr_reg, terr_next;
  logic               last_b_reg, last_b_next;  // 1 = port B granted last
  logic [1:0]         grant;

  rr_arb2 u_rr_arb2 (
    .req        ({i_b_req, i_a_req}),
    .last_grant (last_b_reg),
    .grant      (grant)
  );

  always_comb begin
    logic               done;
    logic               abort;
    logic [SRAM_DW-1:0] result;

    state_next   = state_reg;
    lat_next     = lat_reg;
    cnt_next     = cnt_reg;
    rden_next    = rden_reg;
    wren_next    = wren_reg;
    a_ack_next   = 1'b0;
    b_ack_next   = 1'b0;
    a_rdata_next = a_rdata_reg;
    b_rdata_next = b_rdata_reg;
    terr_next    = terr_reg;
    last_b_next  = last_b_reg;
    done         = 1'b0;
    abort        = 1'b0;
    result       = '0;

    unique case (state_reg)
      IDLE: begin
        // i_mem_ack is deliberately not looked at here.
        if (grant[0]) begin
          state_next  = BUSY_A;
          lat_next    = make_req(i_a_wren, i_a_addr, i_a_wdata, i_a_bmask);
          last_b_next = 1'b0;
          cnt_next    = '0;
          wren_next   = i_a_wren;
          rden_next   = ~i_a_wren;
        end else if (grant[1]) begin
          state_next  = BUSY_B;
          lat_next    = make_req(i_b_wren, i_b_addr, i_b_wdata, i_b_bmask);
          last_b_next = 1'b1;
          cnt_next    = '0;
          wren_next   = i_b_wren;
          rden_next   = ~i_b_wren;
        end
      end

      BUSY_A, BUSY_B: begin
        // A real ack in the final counter cycle wins over the abort.
        if (i_mem_ack) begin
          done = 1'b1;
        end else if (cnt_reg == CNT_LAST) begin
          done  = 1'b1;
          abort = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end

        if (done) begin
          state_next = IDLE;
          rden_next  = 1'b0;
          wren_next  = 1'b0;
          result     = abort ? '0 : i_mem_rdata;
          if (abort) terr_next = 1'b1;
          if (state_reg == BUSY_B) begin
            b_ack_next = 1'b1;
            if (!lat_reg.wren) b_rdata_next = result;
          end else begin
            a_ack_next = 1'b1;
            if (!lat_reg.wren) a_rdata_next = result;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= IDLE;
      lat_reg     <= '0;
      cnt_reg     <= '0;
      rden_reg    <= 1'b0;
      wren_reg    <= 1'b0;
      a_ack_reg   <= 1'b0;
      b_ack_reg   <= 1'b0;
      a_rdata_reg <= '0;
      b_rdata_reg <= '0;
      terr_reg    <= 1'b0;
      last_b_reg  <= 1'b1;  // so that A wins the first tie
    end else begin
      state_reg   <= state_next;
      lat_reg     <= lat_next;
      cnt_reg     <= cnt_next;
      rden_reg    <= rden_next;
      wren_reg    <= wren_next;
      a_ack_reg   <= a_ack_next;
      b_ack_reg   <= b_ack_next;
      a_rdata_reg <= a_rdata_next;
      b_rdata_reg <= b_rdata_next;
      terr_reg    <= terr_next;
      last_b_reg  <= last_b_next;
    end
  end

  assign o_mem_addr    = lat_reg.addr;
  assign o_mem_wdata   = lat_reg.wdata;
  assign o_mem_bmask   = lat_reg.bmask;
  assign o_mem_wren    = wren_reg;
  assign o_mem_rden    = rden_reg;
  assign o_a_ack       = a_ack_reg;
  assign o_b_ack       = b_ack_reg;
  assign o_a_rdata     = a_rdata_reg;
  assign o_b_rdata     = b_rdata_reg;
  assign o_timeout_err = terr_reg;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised scoreboard bench for sram_port_arbiter.
module tb_sram_port_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_a_req, i_a_wren, i_b_req, i_b_wren;
  logic [17:0] i_a_addr, i_b_addr;
  logic [31:0] i_a_wdata, i_b_wdata;
  logic [3:0]  i_a_bmask, i_b_bmask;
  logic [31:0] o_a_rdata, o_b_rdata;
  logic        o_a_ack, o_b_ack;
  logic [17:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        o_mem_wren, o_mem_rden;
  logic [31:0] i_mem_rdata;
  logic        i_mem_ack;
  logic        o_timeout_err;

  sram_port_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_req(i_a_req), .i_a_wren(i_a_wren), .i_a_addr(i_a_addr),
    .i_a_wdata(i_a_wdata), .i_a_bmask(i_a_bmask),
    .i_b_req(i_b_req), .i_b_wren(i_b_wren), .i_b_addr(i_b_addr),
    .i_b_wdata(i_b_wdata), .i_b_bmask(i_b_bmask),
    .o_a_rdata(o_a_rdata), .o_a_ack(o_a_ack),
    .o_b_rdata(o_b_rdata), .o_b_ack(o_b_ack),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_bmask(o_mem_bmask), .o_mem_wren(o_mem_wren),
    .o_mem_rden(o_mem_rden), .i_mem_rdata(i_mem_rdata),
    .i_mem_ack(i_mem_ack), .o_timeout_err(o_timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port_b;
    logic [31:0] rdata;
    logic        terr;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state (transaction level).
  logic        a_pend, b_pend;
  logic        last_b_m;
  logic [31:0] a_rd_m, b_rd_m;
  logic        terr_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a port acknowledges.
  always @(negedge clk) begin
    if (rst_n && (o_a_ack || o_b_ack)) begin
      exp_t e;
      chk("ack_exclusive", {31'd0, o_a_ack & o_b_ack}, 32'd0);
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ack: a_ack=%b b_ack=%b with nothing outstanding", o_a_ack, o_b_ack);
      end else begin
        e = sb_q.pop_front();
        chk("ack_port", {31'd0, o_b_ack}, {31'd0, e.port_b});
        chk("ack_rdata", e.port_b ? o_b_rdata : o_a_rdata, e.rdata);
        chk("ack_terr", {31'd0, o_timeout_err}, {31'd0, e.terr});
        $display("txn done port=%s rdata=%h terr=%b", e.port_b ? "B" : "A",
                 e.port_b ? o_b_rdata : o_a_rdata, o_timeout_err);
      end
    end
  end

  task automatic rand_a();
    i_a_wren  = 1'($urandom_range(0, 1));
    i_a_addr  = 18'($urandom);
    i_a_wdata = $urandom;
    i_a_bmask = 4'($urandom_range(1, 15));
  endtask

  task automatic rand_b();
    i_b_wren  = 1'($urandom_range(0, 1));
    i_b_addr  = 18'($urandom);
    i_b_wdata = $urandom;
    i_b_bmask = 4'($urandom_range(1, 15));
  endtask

  // Called at a negedge with the request inputs already set and the DUT
  // idle. delay = BUSY cycle in which the memory acks (> TO: never acks).
  task automatic serve(input int delay, input logic [31:0] mdata,
                       input bit drop_mid, input bit keep_after);
    logic        win_b, wr, got;
    logic [17:0] ad;
    logic [31:0] wd;
    logic [3:0]  bm;
    bit          tmo, held_ok;
    int          end_cyc;
    exp_t        e;

    win_b    = (a_pend && b_pend) ? ~last_b_m : b_pend;
    last_b_m = win_b;
    wr = win_b ? i_b_wren  : i_a_wren;
    ad = win_b ? i_b_addr  : i_a_addr;
    wd = win_b ? i_b_wdata : i_a_wdata;
    bm = win_b ? i_b_bmask : i_a_bmask;

    @(negedge clk);  // first BUSY cycle
    chk("no_stale_ack", {31'd0, o_a_ack | o_b_ack}, 32'd0);
    chk("grant_rden", {31'd0, o_mem_rden}, {31'd0, ~wr});
    chk("grant_wren", {31'd0, o_mem_wren}, {31'd0, wr});
    chk("grant_addr", {14'd0, o_mem_addr}, {14'd0, ad});
    chk("grant_wdata", o_mem_wdata, wd);
    chk("grant_bmask", {28'd0, o_mem_bmask}, {28'd0, bm});

    if (drop_mid) begin
      if (win_b) i_b_req = 1'b0; else i_a_req = 1'b0;
    end

    tmo     = (delay > TO);
    end_cyc = tmo ? TO : delay;
    e.port_b = win_b;
    if (wr)       e.rdata = win_b ? b_rd_m : a_rd_m;
    else if (tmo) e.rdata = 32'd0;
    else          e.rdata = mdata;
    if (win_b) b_rd_m = e.rdata; else a_rd_m = e.rdata;
    if (tmo) terr_m = 1'b1;
    e.terr = terr_m;
    sb_q.push_back(e);

    held_ok = 1'b1;
    for (int c = 1; c <= end_cyc; c++) begin
      if (o_mem_rden !== ~wr || o_mem_wren !== wr || o_mem_addr !== ad) held_ok = 1'b0;
      if (c == end_cyc && !tmo) begin
        i_mem_ack   = 1'b1;
        i_mem_rdata = mdata;
      end else begin
        i_mem_ack   = 1'b0;
        i_mem_rdata = $urandom;
      end
      @(negedge clk);
    end
    i_mem_ack = 1'b0;

    chk("busy_held", {31'd0, held_ok}, 32'd1);
    got = win_b ? o_b_ack : o_a_ack;
    chk("ack_timing", {31'd0, got}, 32'd1);
    chk("idle_after_done", {30'd0, o_mem_rden, o_mem_wren}, 32'd0);

    if (win_b) begin
      if (keep_after) begin rand_b(); i_b_req = 1'b1; b_pend = 1'b1; end
      else begin i_b_req = 1'b0; b_pend = 1'b0; end
    end else begin
      if (keep_after) begin rand_a(); i_a_req = 1'b1; a_pend = 1'b1; end
      else begin i_a_req = 1'b0; a_pend = 1'b0; end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_ack"}, {31'd0, o_a_ack}, 32'd0);
    chk({tag, "_b_ack"}, {31'd0, o_b_ack}, 32'd0);
    chk({tag, "_mem_en"}, {30'd0, o_mem_rden, o_mem_wren}, 32'd0);
    chk({tag, "_mem_addr"}, {14'd0, o_mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, o_mem_wdata, 32'd0);
    chk({tag, "_mem_bmask"}, {28'd0, o_mem_bmask}, 32'd0);
    chk({tag, "_a_rdata"}, o_a_rdata, 32'd0);
    chk({tag, "_b_rdata"}, o_b_rdata, 32'd0);
    chk({tag, "_terr"}, {31'd0, o_timeout_err}, 32'd0);
  endtask

  task automatic model_reset();
    last_b_m = 1'b1;
    a_rd_m   = '0;
    b_rd_m   = '0;
    terr_m   = 1'b0;
    a_pend   = 1'b0;
    b_pend   = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    i_a_req = 0; i_a_wren = 0; i_a_addr = '0; i_a_wdata = '0; i_a_bmask = '0;
    i_b_req = 0; i_b_wren = 0; i_b_addr = '0; i_b_wdata = '0; i_b_bmask = '0;
    i_mem_rdata = '0; i_mem_ack = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single read on A with ack in the third BUSY cycle.
    i_a_wren = 0; i_a_addr = 18'h02000; i_a_wdata = '0; i_a_bmask = 4'hF;
    i_a_req = 1; a_pend = 1;
    serve(3, 32'hDEADBEEF, 0, 0);

    // Write on B; B's read data must not change.
    i_b_wren = 1; i_b_addr = 18'h00010; i_b_wdata = 32'h12345678; i_b_bmask = 4'b0011;
    i_b_req = 1; b_pend = 1;
    serve(2, 32'hCAFEF00D, 0, 0);

    // Both held: alternating grants.
    rand_a(); rand_b();
    i_a_req = 1; i_b_req = 1; a_pend = 1; b_pend = 1;
    for (int k = 0; k < 4; k++) serve(2, $urandom, 0, 1);
    serve(2, $urandom, 0, 0);
    serve(2, $urandom, 0, 0);

    // Read on A never acknowledged: abort after TO BUSY cycles.
    i_a_wren = 0; i_a_addr = 18'h01234; i_a_bmask = 4'hF;
    i_a_req = 1; a_pend = 1;
    serve(TO + 4, 32'h55555555, 0, 0);
    repeat (3) @(negedge clk);
    chk("terr_sticky", {31'd0, o_timeout_err}, 32'd1);
    rand_b(); i_b_req = 1; b_pend = 1;
    serve(1, $urandom, 0, 0);

    // Reset in the second BUSY cycle of a B transaction.
    rand_b(); i_b_req = 1;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    i_a_req = 0; i_b_req = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_quiet", {30'd0, o_mem_rden, o_mem_wren}, 32'd0);
    rand_a(); rand_b();
    i_a_req = 1; i_b_req = 1; a_pend = 1; b_pend = 1;
    serve(2, $urandom, 0, 0);
    serve(2, $urandom, 0, 0);

    // Ack arriving in exactly the timeout cycle completes normally.
    i_a_wren = 0; i_a_addr = 18'h3FFFC; i_a_bmask = 4'hF;
    i_a_req = 1; a_pend = 1;
    serve(TO, 32'hA5A5A5A5, 0, 0);
    @(negedge clk);
    chk("terr_clear", {31'd0, o_timeout_err}, 32'd0);

    // Randomised traffic.
    for (int t = 0; t < 150; t++) begin
      int r, d;
      if (!a_pend && $urandom_range(0, 2) != 0) begin rand_a(); i_a_req = 1; a_pend = 1; end
      if (!b_pend && $urandom_range(0, 2) != 0) begin rand_b(); i_b_req = 1; b_pend = 1; end
      if (!a_pend && !b_pend) begin
        i_mem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        i_mem_ack = 1'b0;
        chk("idle_quiet", {30'd0, o_mem_rden, o_mem_wren}, 32'd0);
        continue;
      end
      r = $urandom_range(0, 19);
      if (r == 0)      d = TO + 3;
      else if (r == 1) d = TO;
      else if (r == 2) d = TO - 1;
      else             d = $urandom_range(1, 6);
      serve(d, $urandom, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
    end

    i_a_req = 0; i_b_req = 0;
    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 16, number of cycles a granted transaction waits for i_mem_ack before it is aborted (legal range 2..255).
REQ-002 The block SHALL have one clock and an asynchronous active-low reset.
REQ-003 i_clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 i_rst_n  in  1  asynchronous active-low reset.
REQ-005 i_a_req / i_b_req  in  1 each  access request, port A (LSU) and port B (instruction fetch).
REQ-006 i_a_wren / i_b_wren  in  1 each  1 = write, 0 = read.
REQ-007 i_a_addr / i_b_addr  in  18 each  SRAM byte address.
REQ-008 i_a_wdata / i_b_wdata  in  32 each  store data.
REQ-009 i_a_bmask / i_b_bmask  in  4 each  byte-lane enables.
REQ-010 o_a_rdata / o_b_rdata  out  32 each  registered read data per port.
REQ-011 o_a_ack / o_b_ack  out  1 each  one-cycle completion pulse per port.
REQ-012 o_mem_addr  out  18; o_mem_wdata  out  32; o_mem_bmask  out  4; o_mem_wren  out  1; o_mem_rden  out  1; all drive the 32-bit SRAM controller.
REQ-013 i_mem_rdata  in  32; i_mem_ack  in  1  returned by the SRAM controller.
REQ-014 o_timeout_err  out  1  sticky flag, set by any aborted transaction.

Function
REQ-015 FSM states: IDLE, BUSY_A, BUSY_B; exactly one transaction outstanding at a time.
REQ-016 IDLE: with no request pending, the FSM SHALL stay in IDLE with o_mem_wren = o_mem_rden = 0.
REQ-017 IDLE with exactly one request SHALL move to that port's BUSY state on the next edge.
REQ-018 IDLE with both requests SHALL grant round-robin: the port not granted last wins; after reset port A wins the first tie.
REQ-019 On grant, the SHALL latch the winner's addr/wdata/bmask/wren into internal registers; all o_mem_* outputs come only from these registers.
REQ-020 In BUSY_x, o_mem_wren = latched wren and o_mem_rden = ~latched wren, held constant until completion.
REQ-021 Latency: a request sampled in IDLE at edge N SHALL produce o_mem_rden/o_mem_wren high during cycle N+1.
REQ-022 i_mem_ack high in BUSY_x at edge M SHALL pulse o_x_ack for exactly cycle M+1 and return to IDLE at the same edge.
REQ-023 For reads, i_mem_rdata at edge M SHALL be captured into o_x_rdata; it is valid with o_x_ack and held until that port's next read completion.
REQ-024 For writes, o_x_rdata SHALL be left unchanged.
REQ-025 A requester holds req and its fields stable until its ack; dropping req mid-transaction does not cancel it, and the ack is still pulsed.
REQ-026 After completion the FSM spends at least one cycle in IDLE, so a held request is re-granted no earlier than edge M+1.
REQ-027 A cycle counter (8 bits) SHALL clear on grant and increment each BUSY cycle; on reaching TIMEOUT_CYC-1 without i_mem_ack, the FSM SHALL abort to IDLE, pulse o_x_ack, load o_x_rdata with 0 on reads, and set o_timeout_err.
REQ-028 If i_mem_ack and the timeout occur in the same cycle, the ack SHALL take precedence: normal completion, no error.
REQ-029 o_a_ack and o_b_ack SHALL never be high in the same cycle.
REQ-030 i_mem_ack while in IDLE SHALL be ignored.

Reset
REQ-031 Asserting i_rst_n low SHALL immediately force IDLE, o_*_ack = 0, o_mem_wren = o_mem_rden = 0, o_mem_addr/wdata/bmask = 0, o_*_rdata = 0, o_timeout_err = 0, counter = 0, and last-grant = B.
REQ-032 Reset mid-transaction SHALL drop it silently, with no ack after release.

Structure
REQ-033 Package sram_arb_pkg SHALL hold the state enum, SRAM_AW = 18, SRAM_DW = 32 and a request struct {wren, addr, wdata, bmask}.
REQ-034 The two-requester round-robin pick logic SHALL be a sub-module, rr_arb2 (req[1:0], last-grant in, one-hot grant out).

Verification
REQ-035 Single read A: addr 0x02000, mem ack after 3 cycles with rdata 0xDEADBEEF -> o_mem_rden high for 3 cycles, then o_a_ack one pulse with o_a_rdata = 0xDEADBEEF.
REQ-036 Simultaneous A and B held after reset, mem acks after 2 cycles -> grant order A, B, A, B; acks never coincide.
REQ-037 Write B: addr 0x00010, wdata 0x12345678, bmask 0011 -> o_mem_wren high with these values latched, o_b_ack pulse, o_b_rdata unchanged.
REQ-038 No mem ack for a read by A, TIMEOUT_CYC = 16 -> abort after 16 BUSY cycles, o_a_ack pulse, o_a_rdata = 0, o_timeout_err = 1 and sticky.
REQ-039 Reset asserted in the second BUSY cycle -> all outputs 0 immediately, no ack after release, next tie won by A.
REQ-040 i_mem_ack on exactly the timeout cycle -> normal completion, o_timeout_err stays 0.
